clip_selector: RTL and testbench
================================

Name: clip_selector

Overview:
- Control stage directly upstream of the seven-segment display driver.
- Debounces the four board buttons and keeps the selected clip index, which it presents as record_clip_o.
- Runs the idle/record/play state machine and issues start/stop handshakes to the audio datapath.
- Drives play_clip_o to the active clip index during playback; drives 4'hF otherwise, which the display shows blank.

Parameters:
NUM_CLIPS, 10, number of clip slots; indices 0..NUM_CLIPS-1; must be ≤15.
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must hold before it is accepted (10 ms at 100 MHz).

Ports:
clock_i  in  1  system clock
reset_i  in  1  asynchronous, active-low reset
btn_next_i  in  1  raw button: select next clip
btn_prev_i  in  1  raw button: select previous clip
btn_record_i  in  1  raw button: start/stop recording
btn_play_i  in  1  raw button: start/stop playback
rec_done_i  in  1  datapath pulse: recording buffer full
play_done_i  in  1  datapath pulse: playback reached end of clip
record_start_o  out  1  one-cycle pulse: start recording into clip record_clip_o
play_start_o  out  1  one-cycle pulse: start playback of clip play_clip_o
stop_o  out  1  one-cycle pulse: abort the current record/play
busy_o  out  1  high in RECORD or PLAY
record_clip_o  out  4  selected clip index
play_clip_o  out  4  clip being played; 4'hF when not in PLAY
clip_valid_o  out  NUM_CLIPS  bit i set once clip i holds a recording

Behaviour:
- Reset: all registers clear immediately on reset_i low. Values: state IDLE, selection 0, clip_valid_o 0, all pulses 0, busy_o 0, record_clip_o 0, play_clip_o 4'hF, debouncers cleared (accepted level 0).
- Button path, per button:
  - 2-flop synchroniser, then a counter that restarts on any change of the synchronised level.
  - The new level is accepted when the counter reaches DEBOUNCE_CYCLES.
  - A rising edge of the accepted level produces a one-cycle press pulse.
  - The press pulse occurs exactly 2+DEBOUNCE_CYCLES cycles after a clean raw rise.
- FSM: reacts to pulses registered in cycle N; outputs change in cycle N+1.
- Priority for same-cycle presses: record > play > next/prev. next and prev together cancel each other.
- IDLE:
  - next: selection+1, wrapping NUM_CLIPS-1 → 0.
  - prev: selection-1, wrapping 0 → NUM_CLIPS-1.
  - record: pulse record_start_o, go to RECORD.
  - play: if clip_valid_o[selection] is set, pulse play_start_o, load play_clip_o with the selection, go to PLAY. If clear, ignore the press (no pulse, no state change).
- RECORD:
  - Selection is frozen; next, prev and play are ignored.
  - rec_done_i, or a record press: set clip_valid_o[selection], go to IDLE.
  - A record press also pulses stop_o. The partial recording is kept as valid.
- PLAY:
  - next, prev and record are ignored.
  - play_done_i: go to IDLE, play_clip_o returns to 4'hF.
  - A play press: same transition, plus a stop_o pulse.
- Done pulse and abort press in the same cycle: the done pulse wins; stop_o is not pulsed.
- rec_done_i or play_done_i arriving outside its own state is ignored.
- busy_o is registered and equals (state != IDLE).
- Reset asserted mid-RECORD or mid-PLAY: immediate return to the reset values. No stop_o pulse; the datapath receives the same reset.

Optional Feature:
CLIP_AUTO_ADVANCE_EN
- Defined: on leaving RECORD by any route, selection advances by 1 with wrap. The next record press therefore records into a fresh slot.
- Undefined: selection stays on the just-recorded clip.

Decomposition:
- Package clip_pkg:
  - NUM_CLIPS default constant
  - clip_idx_t (logic [3:0])
  - CLIP_NONE = 4'hF
  - state enum clip_state_t {IDLE, RECORD, PLAY}
- Sub-module button_debounce: synchroniser, debounce counter and edge detector, parameterised by DEBOUNCE_CYCLES; instantiated four times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset release, then btn_next_i held high for 10 cycles → one press pulse 6 cycles after the rise; record_clip_o 0→1 the following cycle.
2. Bounce: btn_next_i toggles every 2 cycles for 20 cycles, then settles high → exactly one increment. Repeated presses from 9 wrap to 0; prev from 0 gives 9.
3. Record at selection 2, rec_done_i 50 cycles later:
   - one record_start_o pulse; busy_o high;
   - at done: clip_valid_o[2]=1, busy_o=0, no stop_o.
   - With CLIP_AUTO_ADVANCE_EN, record_clip_o becomes 3.
4. Play:
   - Play press on empty clip 5 → no play_start_o, play_clip_o stays 4'hF.
   - Play press on valid clip 2 → play_start_o, play_clip_o=2.
   - Second play press → stop_o pulse, play_clip_o=4'hF.
5. Same-cycle events:
   - record and play press together in IDLE → RECORD only.
   - rec_done_i and record press in the same cycle → IDLE, no stop_o.
6. reset_i driven low asynchronously mid-PLAY → play_clip_o=4'hF, busy_o=0, clip_valid_o=0 before the next clock edge.

Source files
------------

// File: rtl/clip_selector_pkg.sv
// Shared types and helpers for the clip selector control stage.
package clip_pkg;

  // Default number of clip slots; the index type allows up to 15.
  localparam int unsigned DEFAULT_NUM_CLIPS = 10;

  typedef logic [3:0] clip_idx_t;

  // Index value shown blank by the seven-segment driver.
  localparam clip_idx_t CLIP_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } clip_state_t;

  // Step the selection forward, wrapping from the last slot to slot 0.
  function automatic clip_idx_t idx_inc(input clip_idx_t idx, input int unsigned num);
    return (idx == clip_idx_t'(num - 1)) ? clip_idx_t'(0) : idx + 4'd1;
  endfunction

  // Step the selection backward, wrapping from slot 0 to the last slot.
  function automatic clip_idx_t idx_dec(input clip_idx_t idx, input int unsigned num);
    return (idx == clip_idx_t'(0)) ? clip_idx_t'(num - 1) : idx - 4'd1;
  endfunction

endpackage

// File: rtl/clip_selector_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and rising
// edge detector. A clean raw rise yields a one-cycle press pulse exactly
// 2 + DEBOUNCE_CYCLES clock edges later.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Count edges the synchronised level differs from the accepted level; any
  // return to the accepted level restarts the count, so bounces never finish.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
      press_q <= sync_q[1];
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
      press_q <= 1'b0;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clip_selector.sv
// Clip selector: debounces four buttons, keeps the selected clip and runs
// the idle/record/play state machine that drives the audio datapath.
// Optional macro CLIP_AUTO_ADVANCE_EN: when defined, the selection advances
// by one slot (with wrap) every time RECORD is left.
module clip_selector
  import clip_pkg::*;
#(
  parameter int unsigned NUM_CLIPS       = DEFAULT_NUM_CLIPS,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 btn_next_i,
  input  logic                 btn_prev_i,
  input  logic                 btn_record_i,
  input  logic                 btn_play_i,
  input  logic                 rec_done_i,
  input  logic                 play_done_i,
  output logic                 record_start_o,
  output logic                 play_start_o,
  output logic                 stop_o,
  output logic                 busy_o,
  output logic [3:0]           record_clip_o,
  output logic [3:0]           play_clip_o,
  output logic [NUM_CLIPS-1:0] clip_valid_o
);

  logic next_p, prev_p, rec_p, play_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clock_i (clock_i), .reset_i (reset_i), .raw (btn_next_i),   .press (next_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clock_i (clock_i), .reset_i (reset_i), .raw (btn_prev_i),   .press (prev_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_record (
    .clock_i (clock_i), .reset_i (reset_i), .raw (btn_record_i), .press (rec_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
    .clock_i (clock_i), .reset_i (reset_i), .raw (btn_play_i),   .press (play_p)
  );

  clip_state_t          state_q, state_nxt;
  clip_idx_t            sel_q, sel_nxt;
  clip_idx_t            play_clip_q, play_clip_nxt;
  logic [NUM_CLIPS-1:0] valid_q, valid_nxt;
  logic                 rec_start_q, rec_start_nxt;
  logic                 play_start_q, play_start_nxt;
  logic                 stop_q, stop_nxt;
  logic                 busy_q;
  logic [NUM_CLIPS-1:0] sel_mask;
  logic                 sel_valid;

  assign sel_mask  = NUM_CLIPS'(1) << sel_q;
  assign sel_valid = |(valid_q & sel_mask);

  // Register the controller state and every output so all outputs change
  // one cycle after the press pulse that caused them.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      play_clip_q  <= CLIP_NONE;
      valid_q      <= '0;
      rec_start_q  <= 1'b0;
      play_start_q <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      sel_q        <= sel_nxt;
      play_clip_q  <= play_clip_nxt;
      valid_q      <= valid_nxt;
      rec_start_q  <= rec_start_nxt;
      play_start_q <= play_start_nxt;
      stop_q       <= stop_nxt;
      busy_q       <= (state_nxt != IDLE);
    end
  end

  // Next-state logic: record beats play beats navigation, and a done pulse
  // beats an abort press so no stop is issued for a finished transfer.
  always_comb begin
    state_nxt      = state_q;
    sel_nxt        = sel_q;
    play_clip_nxt  = play_clip_q;
    valid_nxt      = valid_q;
    rec_start_nxt  = 1'b0;
    play_start_nxt = 1'b0;
    stop_nxt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rec_p) begin
          rec_start_nxt = 1'b1;
          state_nxt     = RECORD;
        end else if (play_p) begin
          if (sel_valid) begin
            play_start_nxt = 1'b1;
            play_clip_nxt  = sel_q;
            state_nxt      = PLAY;
          end
        end else if (next_p && !prev_p) begin
          sel_nxt = idx_inc(sel_q, NUM_CLIPS);
        end else if (prev_p && !next_p) begin
          sel_nxt = idx_dec(sel_q, NUM_CLIPS);
        end
      end
      RECORD: begin
        if (rec_done_i || rec_p) begin
          valid_nxt = valid_q | sel_mask;
          stop_nxt  = rec_p && !rec_done_i;
          state_nxt = IDLE;
`ifdef CLIP_AUTO_ADVANCE_EN
          sel_nxt   = idx_inc(sel_q, NUM_CLIPS);
`else
          sel_nxt   = sel_q;
`endif
        end
      end
      PLAY: begin
        if (play_done_i || play_p) begin
          stop_nxt      = play_p && !play_done_i;
          play_clip_nxt = CLIP_NONE;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        play_clip_nxt = CLIP_NONE;
      end
    endcase
  end

  assign record_start_o = rec_start_q;
  assign play_start_o   = play_start_q;
  assign stop_o         = stop_q;
  assign busy_o         = busy_q;
  assign record_clip_o  = sel_q;
  assign play_clip_o    = play_clip_q;
  assign clip_valid_o   = valid_q;

endmodule

// File: tb/tb_clip_selector.sv
// Directed bench for clip_selector with DEBOUNCE_CYCLES = 4 (default build).
module tb_clip_selector;
  import clip_pkg::*;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_NEXT = 4'b1000;
  localparam logic [3:0] B_PREV = 4'b0100;
  localparam logic [3:0] B_REC  = 4'b0010;
  localparam logic [3:0] B_PLAY = 4'b0001;
  localparam int NV = 26;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       btn_next_i, btn_prev_i, btn_record_i, btn_play_i;
  logic       rec_done_i, play_done_i;
  logic       record_start_o, play_start_o, stop_o, busy_o;
  logic [3:0] record_clip_o, play_clip_o;
  logic [9:0] clip_valid_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] btns;
    logic       rd;
    logic       pd;
    logic [3:0] rc;
    logic [3:0] pc;
    logic       busy;
    logic       rs;
    logic       ps;
    logic       st;
    logic [9:0] valid;
  } vec_t;

  vec_t vecs[NV];

  clip_selector #(.NUM_CLIPS(10), .DEBOUNCE_CYCLES(4)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .btn_next_i     (btn_next_i),
    .btn_prev_i     (btn_prev_i),
    .btn_record_i   (btn_record_i),
    .btn_play_i     (btn_play_i),
    .rec_done_i     (rec_done_i),
    .play_done_i    (play_done_i),
    .record_start_o (record_start_o),
    .play_start_o   (play_start_o),
    .stop_o         (stop_o),
    .busy_o         (busy_o),
    .record_clip_o  (record_clip_o),
    .play_clip_o    (play_clip_o),
    .clip_valid_o   (clip_valid_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic setButtons(input logic [3:0] b);
    {btn_next_i, btn_prev_i, btn_record_i, btn_play_i} = b;
  endtask

  // Raise buttons, put done pulses on the edge where the FSM sees the press,
  // and return right after the FSM reaction edge.
  task automatic applyStimulus(input logic [3:0] b, input logic rd, input logic pd);
    setButtons(b);
    tick(6);
    rec_done_i  = rd;
    play_done_i = pd;
    tick(1);
    rec_done_i  = 1'b0;
    play_done_i = 1'b0;
  endtask

  task automatic releaseButtons(input string tag);
    tick(1);
    checkOutput({tag, ".pulses_clear"}, 32'({record_start_o, play_start_o, stop_o}), 32'd0);
    tick(2);
    setButtons(B_NONE);
    tick(8);
  endtask

  task automatic pressOnce(input logic [3:0] b);
    applyStimulus(b, 1'b0, 1'b0);
    releaseButtons("nav");
  endtask

  initial begin
    vecs[0]  = '{B_NEXT,          0, 0, 4'd1, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[1]  = '{B_NEXT,          0, 0, 4'd2, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[2]  = '{B_PREV,          0, 0, 4'd1, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[3]  = '{B_NEXT | B_PREV, 0, 0, 4'd1, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[4]  = '{B_NEXT,          0, 0, 4'd2, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[5]  = '{B_PLAY,          0, 0, 4'd2, 4'hF, 0, 0, 0, 0, 10'h000};
    vecs[6]  = '{B_REC,           0, 0, 4'd2, 4'hF, 1, 1, 0, 0, 10'h000};
    vecs[7]  = '{B_NEXT,          0, 0, 4'd2, 4'hF, 1, 0, 0, 0, 10'h000};
    vecs[8]  = '{B_PLAY,          0, 0, 4'd2, 4'hF, 1, 0, 0, 0, 10'h000};
    vecs[9]  = '{B_NONE,          1, 0, 4'd2, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[10] = '{B_PLAY,          0, 0, 4'd2, 4'd2, 1, 0, 1, 0, 10'h004};
    vecs[11] = '{B_NEXT,          0, 0, 4'd2, 4'd2, 1, 0, 0, 0, 10'h004};
    vecs[12] = '{B_NONE,          1, 0, 4'd2, 4'd2, 1, 0, 0, 0, 10'h004};
    vecs[13] = '{B_PLAY,          0, 0, 4'd2, 4'hF, 0, 0, 0, 1, 10'h004};
    vecs[14] = '{B_NONE,          0, 1, 4'd2, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[15] = '{B_NEXT,          0, 0, 4'd3, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[16] = '{B_NEXT,          0, 0, 4'd4, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[17] = '{B_NEXT,          0, 0, 4'd5, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[18] = '{B_PLAY,          0, 0, 4'd5, 4'hF, 0, 0, 0, 0, 10'h004};
    vecs[19] = '{B_REC | B_PLAY,  0, 0, 4'd5, 4'hF, 1, 1, 0, 0, 10'h004};
    vecs[20] = '{B_REC,           1, 0, 4'd5, 4'hF, 0, 0, 0, 0, 10'h024};
    vecs[21] = '{B_REC,           0, 0, 4'd5, 4'hF, 1, 1, 0, 0, 10'h024};
    vecs[22] = '{B_REC,           0, 0, 4'd5, 4'hF, 0, 0, 0, 1, 10'h024};
    vecs[23] = '{B_PLAY,          0, 0, 4'd5, 4'd5, 1, 0, 1, 0, 10'h024};
    vecs[24] = '{B_PLAY,          0, 1, 4'd5, 4'hF, 0, 0, 0, 0, 10'h024};
    vecs[25] = '{B_PLAY,          0, 0, 4'd5, 4'd5, 1, 0, 1, 0, 10'h024};

    reset_i     = 1'b0;
    setButtons(B_NONE);
    rec_done_i  = 1'b0;
    play_done_i = 1'b0;
    tick(3);
    checkOutput("reset.rc",     32'(record_clip_o), 32'd0);
    checkOutput("reset.pc",     32'(play_clip_o),   32'hF);
    checkOutput("reset.busy",   32'(busy_o),        32'd0);
    checkOutput("reset.valid",  32'(clip_valid_o),  32'd0);
    checkOutput("reset.pulses", 32'({record_start_o, play_start_o, stop_o}), 32'd0);
    reset_i = 1'b1;
    tick(2);

    $display("[TB] debounce latency");
    setButtons(B_NEXT);
    tick(6);
    checkOutput("lat.before", 32'(record_clip_o), 32'd0);
    tick(1);
    checkOutput("lat.after", 32'(record_clip_o), 32'd1);
    tick(3);
    setButtons(B_NONE);
    tick(8);
    checkOutput("lat.single", 32'(record_clip_o), 32'd1);

    $display("[TB] bounce filtering");
    for (int i = 0; i < 10; i++) begin
      btn_next_i = (i % 2 == 0);
      tick(2);
    end
    checkOutput("bounce.none", 32'(record_clip_o), 32'd1);
    btn_next_i = 1'b1;
    tick(7);
    checkOutput("bounce.one", 32'(record_clip_o), 32'd2);
    tick(3);
    btn_next_i = 1'b0;
    tick(8);
    checkOutput("bounce.stay", 32'(record_clip_o), 32'd2);

    $display("[TB] wrap");
    for (int i = 0; i < 7; i++) pressOnce(B_NEXT);
    checkOutput("wrap.nine", 32'(record_clip_o), 32'd9);
    pressOnce(B_NEXT);
    checkOutput("wrap.up", 32'(record_clip_o), 32'd0);
    pressOnce(B_PREV);
    checkOutput("wrap.down", 32'(record_clip_o), 32'd9);
    pressOnce(B_NEXT);
    checkOutput("wrap.back", 32'(record_clip_o), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].btns, vecs[i].rd, vecs[i].pd);
      checkOutput($sformatf("v%0d.rc", i),    32'(record_clip_o),  32'(vecs[i].rc));
      checkOutput($sformatf("v%0d.pc", i),    32'(play_clip_o),    32'(vecs[i].pc));
      checkOutput($sformatf("v%0d.busy", i),  32'(busy_o),         32'(vecs[i].busy));
      checkOutput($sformatf("v%0d.rs", i),    32'(record_start_o), 32'(vecs[i].rs));
      checkOutput($sformatf("v%0d.ps", i),    32'(play_start_o),   32'(vecs[i].ps));
      checkOutput($sformatf("v%0d.st", i),    32'(stop_o),         32'(vecs[i].st));
      checkOutput($sformatf("v%0d.valid", i), 32'(clip_valid_o),   32'(vecs[i].valid));
      releaseButtons($sformatf("v%0d", i));
    end

    $display("[TB] async reset during playback");
    checkOutput("areset.pre", 32'(busy_o), 32'd1);
    #2;
    reset_i = 1'b0;
    #1;
    checkOutput("areset.pc",    32'(play_clip_o),   32'hF);
    checkOutput("areset.busy",  32'(busy_o),        32'd0);
    checkOutput("areset.valid", 32'(clip_valid_o),  32'd0);
    checkOutput("areset.rc",    32'(record_clip_o), 32'd0);
    checkOutput("areset.stop",  32'(stop_o),        32'd0);
    tick(2);
    reset_i = 1'b1;
    tick(3);
    checkOutput("areset.idle", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
